// File: rtl/meter_core_if.sv
// meter_core_if: button inputs and display-path outputs of the parking-meter
// countdown core.
//   add[3:0]       coin buttons (level, synchronised, debounced)
//   preset[1:0]    preset buttons (level, synchronised, debounced)
//   count          remaining seconds
//   tick           one-cycle pulse per countdown period
//   expired        count == 0
//   bcd            BCD digits of count, digit 0 in bits [3:0]
//   bcd_valid      bcd currently matches count
//   display_on     anode enable gate, 1 = digits lit
// master = button/display side, slave = meter_core.
interface meter_core_if #(
    parameter int W      = 14,
    parameter int DIGITS = 4
);
    logic [3:0]          add;
    logic [1:0]          preset;
    logic [W-1:0]        count;
    logic                tick;
    logic                expired;
    logic [4*DIGITS-1:0] bcd;
    logic                bcd_valid;
    logic                display_on;

    modport master (
        output add, preset,
        input  count, tick, expired, bcd, bcd_valid, display_on
    );

    modport slave (
        input  add, preset,
        output count, tick, expired, bcd, bcd_valid, display_on
    );
endinterface

// File: rtl/meter_core.sv
// meter_core: parametrised parking-meter countdown core.
// Edge-detects coin and preset buttons, counts down once per divided tick,
// saturates at MAX_COUNT, converts the count to BCD with a sequential
// double-dabble engine and produces the low-time/expired blink gate.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    meter_core_if slave (buttons in, count/tick/expired/bcd/
//          bcd_valid/display_on out)
//
// BCD engine states
//   state   | meaning
//   S_IDLE  | waiting for count to differ from the last converted value
//   S_SHIFT | W double-dabble iterations on the latched source value
//   S_DONE  | publish result, remember converted value
module meter_core #(
    parameter int TICK_DIV   = 100000000,
    parameter int W          = 14,
    parameter int MAX_COUNT  = 9999,
    parameter int DIGITS     = 4,
    parameter int LOW_THRESH = 200,
    parameter int VAL0       = 10,
    parameter int VAL1       = 180,
    parameter int VAL2       = 200,
    parameter int VAL3       = 550,
    parameter int PRESET0    = 10,
    parameter int PRESET1    = 205
) (
    input  logic        clk,
    input  logic        reset,
    meter_core_if.slave bus
);
    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = W + 3;
    localparam int SW = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} bcd_state_t;

    logic [DW-1:0] div;
    logic          tick_w;
    logic [3:0]    add_prev;
    logic [1:0]    preset_prev;
    logic [3:0]    add_rise;
    logic [1:0]    preset_rise;
    logic [AW-1:0] sum;
    logic [AW-1:0] acc;
    logic [W-1:0]  count_q;
    logic [W-1:0]  count_next;
    logic          phase;

    bcd_state_t    state;
    bcd_state_t    state_next;
    logic [W-1:0]  src;
    logic [W-1:0]  last;
    logic [SW-1:0] sreg;
    logic [SW-1:0] adj;
    logic [SW-1:0] bcd_q;
    logic [CW-1:0] bit_cnt;

    assign tick_w = (div == DW'(TICK_DIV - 1));

    // Count update: preset beats adds and the tick; adds saturate before
    // the tick decrement so a saturated meter still counts down.
    always_comb begin
        add_rise    = bus.add & ~add_prev;
        preset_rise = bus.preset & ~preset_prev;
        sum = '0;
        if (add_rise[0]) sum = sum + AW'(VAL0);
        if (add_rise[1]) sum = sum + AW'(VAL1);
        if (add_rise[2]) sum = sum + AW'(VAL2);
        if (add_rise[3]) sum = sum + AW'(VAL3);
        acc = AW'(count_q) + sum;
        if (acc > AW'(MAX_COUNT)) acc = AW'(MAX_COUNT);
        if (tick_w && (acc != '0)) acc = acc - AW'(1);
        if (preset_rise != 2'b00)
            count_next = preset_rise[1] ? W'(PRESET1) : W'(PRESET0);
        else
            count_next = acc[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            add_prev    <= '0;
            preset_prev <= '0;
            count_q     <= '0;
            phase       <= 1'b0;
        end else begin
            div         <= tick_w ? '0 : div + DW'(1);
            add_prev    <= bus.add;
            preset_prev <= bus.preset;
            count_q     <= count_next;
            if (tick_w) phase <= ~phase;
        end
    end

    // Add-3 correction for every BCD digit >= 5 before the shift.
    always_comb begin
        adj = sreg;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (count_q != last) state_next = S_SHIFT;
            S_SHIFT: if (bit_cnt == '0)   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // src stays intact for the whole conversion so DONE can record it as
    // the converted value; bits are fed MSB first by indexing with bit_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            src     <= '0;
            last    <= '0;
            sreg    <= '0;
            bcd_q   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count_q != last) begin
                        src     <= count_q;
                        sreg    <= '0;
                        bit_cnt <= CW'(W - 1);
                    end
                end
                S_SHIFT: begin
                    sreg    <= SW'({adj, src[bit_cnt]});
                    bit_cnt <= bit_cnt - CW'(1);
                end
                S_DONE: begin
                    bcd_q <= sreg;
                    last  <= src;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.count     = count_q;
        bus.tick      = tick_w;
        bus.expired   = (count_q == '0);
        bus.bcd       = bcd_q;
        bus.bcd_valid = (state == S_IDLE) && (last == count_q);
        if (count_q == '0)
            bus.display_on = phase;
        else if (count_q <= W'(LOW_THRESH))
            bus.display_on = ~count_q[0];
        else
            bus.display_on = 1'b1;
    end
endmodule

// File: tb/tb_meter_core.sv
// tb_meter_core: scoreboard bench for meter_core with TICK_DIV = 8.
// A behavioural model (plain arithmetic, timestamps for the BCD engine)
// predicts every output after each clock edge; the driver pushes the
// prediction, the monitor pops and compares one entry per edge.
module tb_meter_core;
   localparam int TD     = 8;
   localparam int W      = 14;
   localparam int DIGITS = 4;

   typedef struct {
      int          count;
      bit          expired;
      bit          tick;
      bit          display_on;
      bit          bcd_valid;
      logic [15:0] bcd;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   meter_core_if #(.W(W), .DIGITS(DIGITS)) bus();

   meter_core #(
      .TICK_DIV(TD), .W(W), .MAX_COUNT(9999), .DIGITS(DIGITS),
      .LOW_THRESH(200), .VAL0(10), .VAL1(180), .VAL2(200), .VAL3(550),
      .PRESET0(10), .PRESET1(205)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   exp_t q[$];
   int   total = 0;
   int   passed = 0;
   int   errors = 0;
   int   fails_shown = 0;
   bit   drive_done = 0;

   int vals[4] = '{10, 180, 200, 550};
   int m_count, m_div, m_phase, m_busy, m_end, m_src, m_last, m_bcdv, m_cyc;
   logic [3:0] m_padd;
   logic [1:0] m_ppre;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x;
      x = v;
      r = '0;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_step(input logic [3:0] a, input logic [1:0] p, input logic r);
      int   c_old, s, acc;
      bit   tk;
      logic [3:0] ra;
      logic [1:0] rp;
      exp_t e;
      m_cyc++;
      if (r) begin
         m_count = 0; m_div = 0; m_phase = 0; m_busy = 0;
         m_src = 0; m_last = 0; m_bcdv = 0; m_padd = '0; m_ppre = '0;
      end else begin
         c_old = m_count;
         ra = a & ~m_padd;
         rp = p & ~m_ppre;
         tk = (m_div == TD - 1);
         if (rp != 0) begin
            m_count = rp[1] ? 205 : 10;
         end else begin
            s = 0;
            for (int i = 0; i < 4; i++) if (ra[i]) s += vals[i];
            acc = m_count + s;
            if (acc > 9999) acc = 9999;
            if (tk && acc > 0) acc--;
            m_count = acc;
         end
         // Engine: starts on the edge after it sees a new value while
         // idle, publishes W+1 edges later, idle again afterwards.
         if (!m_busy) begin
            if (c_old != m_last) begin
               m_busy = 1;
               m_src  = c_old;
               m_end  = m_cyc + W + 1;
            end
         end else if (m_cyc == m_end) begin
            m_last = m_src;
            m_bcdv = m_src;
            m_busy = 0;
         end
         if (tk) m_phase ^= 1;
         m_div  = (m_div + 1) % TD;
         m_padd = a;
         m_ppre = p;
      end
      e.count      = m_count;
      e.expired    = (m_count == 0);
      e.tick       = (m_div == TD - 1);
      if (m_count > 200)     e.display_on = 1'b1;
      else if (m_count > 0)  e.display_on = (m_count % 2 == 0);
      else                   e.display_on = m_phase[0];
      e.bcd_valid  = !m_busy && (m_last == m_count);
      e.bcd        = to_bcd(m_bcdv);
      q.push_back(e);
   endtask

   task automatic drive(input logic [3:0] a, input logic [1:0] p, input logic r);
      @(negedge clk);
      bus.add    = a;
      bus.preset = p;
      reset      = r;
      model_step(a, p, r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(4'b0, 2'b0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         errors++;
         if (fails_shown < 40) begin
            fails_shown++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
         end
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("count",      32'(bus.count),      32'(e.count));
            chk("expired",    32'(bus.expired),    32'(e.expired));
            chk("tick",       32'(bus.tick),       32'(e.tick));
            chk("display_on", 32'(bus.display_on), 32'(e.display_on));
            chk("bcd_valid",  32'(bus.bcd_valid),  32'(e.bcd_valid));
            chk("bcd",        32'(bus.bcd),        32'(e.bcd));
         end
      end
   end

   initial begin : driver
      logic [3:0] a;
      logic [1:0] p;
      bus.add = '0; bus.preset = '0; reset = 1'b1;
      m_cyc = 0;
      m_padd = '0; m_ppre = '0;
      m_count = 0; m_div = 0; m_phase = 0; m_busy = 0;
      m_src = 0; m_last = 0; m_bcdv = 0; m_end = 0;

      repeat (3) drive(4'b0, 2'b0, 1'b1);
      idle(24);

      // Held add[3] counts once, then ticks and BCD conversion.
      for (int i = 0; i < 20; i++) drive(4'b1000, 2'b0, 1'b0);
      idle(40);

      // Simultaneous adds, then saturation.
      drive(4'b0, 2'b0, 1'b1);
      drive(4'b0101, 2'b0, 1'b0);
      idle(2);
      for (int i = 0; i < 18; i++) begin
         drive(4'b1000, 2'b0, 1'b0);
         idle(1);
      end
      drive(4'b0001, 2'b0, 1'b0);
      idle(20);

      // Preset with add in a tick cycle, then both presets together.
      while (m_div != TD - 1) idle(1);
      drive(4'b1000, 2'b01, 1'b0);
      idle(20);
      drive(4'b0, 2'b11, 1'b0);
      idle(3);
      drive(4'b0, 2'b0, 1'b0);

      // Run 205 down to 0 and beyond.
      drive(4'b0, 2'b10, 1'b0);
      idle(205 * TD + 60);

      // Count changes every 4 cycles during conversion.
      for (int i = 0; i < 6; i++) begin
         drive(4'b0001, 2'b0, 1'b0);
         drive(4'b0001, 2'b0, 1'b0);
         idle(2);
      end
      idle(40);

      // Reset while a button rises and stays held afterwards.
      drive(4'b0100, 2'b0, 1'b1);
      drive(4'b0100, 2'b0, 1'b0);
      idle(25);

      // Random: busy buttons, then sparse activity heading to zero.
      for (int i = 0; i < 1500; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
         p = ($urandom_range(0, 80) == 0) ? 2'($urandom_range(1, 3)) : 2'b0;
         drive(a, p, $urandom_range(0, 700) == 0);
      end
      for (int i = 0; i < 2500; i++) begin
         a = ($urandom_range(0, 150) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
         p = ($urandom_range(0, 100) == 0) ? 2'b01 : 2'b0;
         drive(a, p, $urandom_range(0, 1500) == 0);
      end
      idle(5);
      drive_done = 1;
   end

   initial begin : finisher
      wait (drive_done);
      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", 32'(q.size()), 32'd0);
      if (errors == 0)
         $display("PASS: %0d/%0d checks passed", passed, total);
      else
         $display("FAIL: %0d/%0d checks failed", errors, total);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
